// File: rtl/cuenta_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cuenta_pkg
// Purpose  : Shared definitions for the cuenta_regresiva down-counter:
//            FSM state width and state encodings.
// Contents : c_state_w  - state register width
//            state_t    - ST_IDLE=0, ST_RUN=1, ST_DONE=2 (code 3 unused)
// Revision : 1.0 - initial release
// ============================================================================
package cuenta_pkg;

  localparam int c_state_w = 2;

  typedef enum logic [c_state_w-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : cuenta_pkg
`default_nettype wire

// File: rtl/cuenta_regresiva_decrementador.sv
`default_nettype none
// ============================================================================
// Module   : decrementador
// Purpose  : Combinational next-value logic for the down-counter, q_next = q-1
//            at WIDTH bits. Counterpart of the team's incrementer.
// Ports    : q      in  WIDTH  current count
//            q_next out WIDTH  current count minus one
// Revision : 1.0 - initial release
// ============================================================================
module decrementador #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  // The caller never applies this result while q==0, so wrap is never seen.
  assign q_next = q - WIDTH'(1);

endmodule : decrementador
`default_nettype wire

// File: rtl/cuenta_regresiva.sv
`default_nettype none
// ============================================================================
// Module   : cuenta_regresiva
// Purpose  : Loadable down-counter/timer. Loads a start value, counts Q down
//            to 0 one per clock (pausable), then pulses done for one cycle.
//            With AUTO_RELOAD=1 the latched start value is reloaded and the
//            count repeats until abort.
// Ports    : clk      in  1      clock, rising edge
//            rst      in  1      asynchronous active-high reset
//            start    in  1      begin a count (honoured in IDLE only)
//            load_val in  WIDTH  start value, sampled with start
//            pause    in  1      hold Q while running
//            abort    in  1      back to IDLE with Q=0, highest priority
//            Q        out WIDTH  current count (registered)
//            busy     out 1      state is RUN or DONE
//            done     out 1      state is DONE (one-cycle pulse)
//            zero     out 1      Q==0
// Revision : 1.0 - initial release
// ============================================================================
module cuenta_regresiva
  import cuenta_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_q_dec;

  decrementador #(
    .WIDTH (WIDTH)
  ) u_dec (
    .q      (r_q),
    .q_next (w_q_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_reload <= '0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_q      <= load_val;
            r_reload <= load_val;
            r_state  <= (load_val != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (r_q == '0) begin
            // Not reachable in normal operation; finish rather than wrap.
            r_state <= ST_DONE;
          end else if (!pause) begin
            r_q <= w_q_dec;
            if (r_q == WIDTH'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (AUTO_RELOAD) begin
            r_q     <= r_reload;
            r_state <= (r_reload != '0) ? ST_RUN : ST_DONE;
          end else begin
            r_q     <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          // Unused encoding: recover to a clean idle.
          r_state <= ST_IDLE;
          r_q     <= '0;
        end
      endcase
    end
  end

  assign Q    = r_q;
  assign busy = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done = (r_state == ST_DONE);
  assign zero = (r_q == '0);

endmodule : cuenta_regresiva
`default_nettype wire
